alu_control_seq: RTL and testbench

- Parametrised, registered successor of the combinational ALU control decoder, for the pipelined/multi-cycle datapath.
- Decodes {alu_op_i, alu_function_i} into a 4-bit ALU operation code and registers it into the EX stage.
- Adds an FSM that sequences multi-cycle MULT/DIVU operations: stalls upstream and signals start/done to the iterative multiplier/divider.

---
 rtl/alu_control_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_control_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered ALU control decoder with a small FSM that
// sequences multi-cycle MULT/DIVU operations through the iterative unit.
// Decodes {alu_op_i, alu_function_i} into a 4-bit operation code, registers it
// into EX, stalls upstream while MULT/DIVU are busy and pulses start/done.
// Optional macro ALU_CTRL_STALL_CNT_EN: enables a 32-bit free-running
// stall-cycle counter on stall_cycles_o (tied to zero when undefined).
module alu_control_seq #(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_WIDTH   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [2:0]  alu_op_i,
    input  logic [5:0]  alu_function_i,
    output logic [3:0]  alu_operation_o,
    output logic        valid_o,
    output logic        stall_o,
    output logic        start_o,
    output logic        done_o,
    output logic        illegal_o,
    output logic [31:0] stall_cycles_o
);

    typedef enum logic [3:0] {
        OP_ADD     = 4'b0000,
        OP_SUB     = 4'b0001,
        OP_OR      = 4'b0010,
        OP_ORI     = 4'b0011,
        OP_SRL     = 4'b0100,
        OP_SLL     = 4'b0101,
        OP_LUI     = 4'b0110,
        OP_ANDI    = 4'b0111,
        OP_LW      = 4'b1000,
        OP_SW      = 4'b1001,
        OP_MULT    = 4'b1010,
        OP_DIVU    = 4'b1011,
        OP_NOR     = 4'b1100,
        OP_AND     = 4'b1101,
        OP_SLT     = 4'b1110,
        OP_ILLEGAL = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } state_e;

    // Counter preload: busy lasts exactly LATENCY cycles, ending on cnt==0.
    localparam logic [CNT_WIDTH-1:0] MUL_CNT_INIT = CNT_WIDTH'(MUL_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_CNT_INIT = CNT_WIDTH'(DIV_LATENCY - 1);

    logic [8:0]           sel;
    alu_op_e              dec;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    alu_op_e              op_q, op_d;
    logic                 valid_q, valid_d;
    logic                 start_q, start_d;
    logic                 done_q, done_d;
    logic                 illegal_q, illegal_d;
    logic                 accept;

    assign sel = {alu_op_i, alu_function_i};

    // Combinational decode of the ALUOp/funct selector.
    always_comb begin
        dec = OP_ILLEGAL;
        casez (sel)
            9'b111_100000: dec = OP_ADD;
            9'b000_??????: dec = OP_ADD;
            9'b111_100010: dec = OP_SUB;
            9'b111_100101: dec = OP_OR;
            9'b001_??????: dec = OP_ORI;
            9'b111_000010: dec = OP_SRL;
            9'b111_000000: dec = OP_SLL;
            9'b010_??????: dec = OP_LUI;
            9'b011_??????: dec = OP_ANDI;
            9'b100_??????: dec = OP_LW;
            9'b101_??????: dec = OP_SW;
            9'b111_011000: dec = OP_MULT;
            9'b111_011011: dec = OP_DIVU;
            9'b111_100111: dec = OP_NOR;
            9'b111_100100: dec = OP_AND;
            9'b111_101010: dec = OP_SLT;
            default:       dec = OP_ILLEGAL;
        endcase
    end

    assign accept = valid_i && !flush_i;

    // Next-state and registered-output logic for the sequencing FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        valid_d   = 1'b0;
        start_d   = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = dec;
                    valid_d   = 1'b1;
                    illegal_d = (dec == OP_ILLEGAL);
                    if (dec == OP_MULT) begin
                        state_d = MUL_BUSY;
                        cnt_d   = MUL_CNT_INIT;
                        start_d = 1'b1;
                    end else if (dec == OP_DIVU) begin
                        state_d = DIV_BUSY;
                        cnt_d   = DIV_CNT_INIT;
                        start_d = 1'b1;
                    end
                end
            end
            MUL_BUSY, DIV_BUSY: begin
                // Flush wins over completion, so a killed op never reports done.
                if (flush_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    op_d    = OP_ILLEGAL;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= OP_ILLEGAL;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign alu_operation_o = op_q;
    assign valid_o         = valid_q;
    assign start_o         = start_q;
    assign done_o          = done_q;
    assign illegal_o       = illegal_q;
    assign stall_o         = (state_q != IDLE);

`ifdef ALU_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Free-running count of stalled cycles; wraps naturally, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall_o) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: stimulus pushes expected EX-stage
// events, a negedge monitor pops and compares on valid_o/done_o.
module tb_alu_control_seq;

    logic        clk;
    logic        reset;
    logic        valid0, valid1, flush;
    logic [2:0]  aop;
    logic [5:0]  afn;

    logic [3:0]  op_o,  op1_o;
    logic        valid_o, stall_o, start_o, done_o, illegal_o;
    logic        valid1_o, stall1_o, start1_o, done1_o, illegal1_o;
    logic [31:0] scnt_o, scnt1_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit       is_done;
        bit [3:0] op;
        bit       ill;
        bit       start;
        bit       stall;
    } exp_t;

    exp_t sb[$];

    alu_control_seq #(.MUL_LATENCY(4), .DIV_LATENCY(32), .CNT_WIDTH(6)) u_dut (
        .clk(clk), .reset(reset), .valid_i(valid0), .flush_i(flush),
        .alu_op_i(aop), .alu_function_i(afn),
        .alu_operation_o(op_o), .valid_o(valid_o), .stall_o(stall_o),
        .start_o(start_o), .done_o(done_o), .illegal_o(illegal_o),
        .stall_cycles_o(scnt_o)
    );

    alu_control_seq #(.MUL_LATENCY(1), .DIV_LATENCY(1), .CNT_WIDTH(6)) u_dut1 (
        .clk(clk), .reset(reset), .valid_i(valid1), .flush_i(flush),
        .alu_op_i(aop), .alu_function_i(afn),
        .alu_operation_o(op1_o), .valid_o(valid1_o), .stall_o(stall1_o),
        .start_o(start1_o), .done_o(done1_o), .illegal_o(illegal1_o),
        .stall_cycles_o(scnt1_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] stall_exp(input int n);
`ifdef ALU_CTRL_STALL_CNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_done, input bit [3:0] op, input bit ill,
                        input bit start, input bit stall);
        exp_t e;
        e.is_done = is_done;
        e.op      = op;
        e.ill     = ill;
        e.start   = start;
        e.stall   = stall;
        sb.push_back(e);
    endtask

    // Present one instruction on the main DUT for one cycle and log its expected acceptance.
    task automatic send(input logic [8:0] s, input bit [3:0] exp_op);
        bit busy;
        busy = (exp_op == 4'b1010) || (exp_op == 4'b1011);
        {aop, afn} = s;
        valid0 = 1'b1;
        push(1'b0, exp_op, exp_op == 4'b1111, busy, busy);
        tick();
        valid0 = 1'b0;
    endtask

    // Monitor: compare every presented output against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            check("pulse_qual", 32'((start_o || illegal_o) && !valid_o), 32'd0);
            if (valid_o || done_o) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: valid_o=%b done_o=%b op=%h, expected no output",
                             valid_o, done_o, op_o);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind_done", 32'(done_o), 32'(e.is_done));
                    check("sb_kind_valid", 32'(valid_o), 32'(!e.is_done));
                    check("sb_op", 32'(op_o), 32'(e.op));
                    check("sb_illegal", 32'(illegal_o), 32'(e.ill));
                    check("sb_start", 32'(start_o), 32'(e.start));
                    check("sb_stall", 32'(stall_o), 32'(e.stall));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [8:0] s;
        bit   [3:0] op;
    } vec_t;

    vec_t vecs[$] = '{
        '{9'b111_100000, 4'b0000}, '{9'b011_101010, 4'b0111},
        '{9'b111_110011, 4'b1111}, '{9'b000_010101, 4'b0000},
        '{9'b111_100010, 4'b0001}, '{9'b111_100101, 4'b0010},
        '{9'b001_111111, 4'b0011}, '{9'b111_000010, 4'b0100},
        '{9'b111_000000, 4'b0101}, '{9'b010_000001, 4'b0110},
        '{9'b100_100000, 4'b1000}, '{9'b101_000011, 4'b1001},
        '{9'b110_100000, 4'b1111}, '{9'b111_100111, 4'b1100},
        '{9'b111_100100, 4'b1101}, '{9'b111_011001, 4'b1111},
        '{9'b111_101010, 4'b1110}, '{9'b011_000000, 4'b0111}
    };

    initial begin
        reset = 1'b0; valid0 = 1'b0; valid1 = 1'b0; flush = 1'b0;
        aop = '0; afn = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_op", 32'(op_o), 32'hF);
        check("rst_pulses", 32'({valid_o, stall_o, start_o, done_o, illegal_o}), 32'd0);
        check("rst_scnt", scnt_o, 32'd0);
        reset = 1'b1;
        tick();

        // Decode table, back-to-back acceptance.
        foreach (vecs[i]) send(vecs[i].s, vecs[i].op);
        tick();
        check("idle_hold", 32'(op_o), 32'h7);

        // Flush in IDLE: not accepted, operation code holds.
        {aop, afn} = 9'b111_100010;
        valid0 = 1'b1;
        flush = 1'b1;
        tick();
        valid0 = 1'b0;
        flush = 1'b0;
        tick();
        check("idle_flush_hold", 32'(op_o), 32'h7);

        // MULT, latency 4, with upstream holding ADD throughout busy.
        send(9'b111_011000, 4'b1010);
        push(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
        push(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        {aop, afn} = 9'b111_100000;
        valid0 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("mul_stall_hi", 32'(stall_o), 32'd1);
            tick();
        end
        check("mul_stall_lo", 32'(stall_o), 32'd0);
        check("mul_scnt", scnt_o, stall_exp(4));
        tick();
        valid0 = 1'b0;
        check("mul_next_op", 32'(op_o), 32'h0);

        // DIVU flushed at busy cycle 10.
        send(9'b111_011011, 4'b1011);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("div_flush_stall", 32'(stall_o), 32'd0);
        check("div_flush_op", 32'(op_o), 32'hF);
        check("div_flush_done", 32'(done_o), 32'd0);
        check("div_flush_scnt", scnt_o, stall_exp(14));
        repeat (3) tick();

        // MULT flushed in its final busy cycle: flush beats completion.
        send(9'b111_011000, 4'b1010);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("mul_flush_done", 32'(done_o), 32'd0);
        check("mul_flush_op", 32'(op_o), 32'hF);
        check("mul_flush_scnt", scnt_o, stall_exp(18));
        repeat (2) tick();

        // Asynchronous reset at busy cycle 3 of a DIVU.
        send(9'b111_011011, 4'b1011);
        repeat (2) tick();
        #2;
        reset = 1'b0;
        #1;
        check("arst_op", 32'(op_o), 32'hF);
        check("arst_pulses", 32'({valid_o, stall_o, start_o, done_o, illegal_o}), 32'd0);
        check("arst_scnt", scnt_o, 32'd0);
        tick();
        reset = 1'b1;
        send(9'b111_100000, 4'b0000);
        tick();

        // Latency-1 instance: start and stall together, done the next cycle.
        {aop, afn} = 9'b111_011000;
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        check("l1_op", 32'(op1_o), 32'hA);
        check("l1_cycle1", 32'({valid1_o, start1_o, stall1_o, done1_o}), 32'b1110);
        tick();
        check("l1_cycle2", 32'({valid1_o, start1_o, stall1_o, done1_o}), 32'b0001);
        check("l1_scnt", scnt1_o, stall_exp(1));
        tick();
        check("l1_cycle3", 32'({valid1_o, start1_o, stall1_o, done1_o, illegal1_o}), 32'd0);

        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
